// File: rtl/prio_enc_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc_seg_scan
// Purpose  : Registered priority encoder with a valid/ready input handshake
//            and a time-multiplexed, common-anode hex 7-segment readout of
//            the encoded index.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous reset, active-high
//   in_valid   in   1       x is valid this cycle
//   in_ready   out  1       block can accept x (high in IDLE)
//   x          in   WIDTH   request vector, bit WIDTH-1 highest priority
//   out_valid  out  1       one-cycle pulse: y and empty just updated
//   y          out  IDX_W   index of highest set bit of last accepted x
//   empty      out  1       last accepted x was all-zero
//   seg        out  7       {a,b,c,d,e,f,g}, active-low
//   an         out  DIGITS  digit enables, active-low, one-hot-low
// Configuration macro
//   BLANK_EMPTY_EN : when defined, seg is dark (all ones) while empty=1;
//                    otherwise the display shows y (=0) while empty=1.
// ============================================================================
module prio_enc_seg_scan #(
  parameter  int WIDTH    = 16,
  parameter  int DIGITS   = 2,
  parameter  int SCAN_DIV = 1000,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  x,
  output logic              out_valid,
  output logic [IDX_W-1:0]  y,
  output logic              empty,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NIB_W = 4 * DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);

`ifdef BLANK_EMPTY_EN
  localparam logic BLANK = 1'b1;
`else
  localparam logic BLANK = 1'b0;
`endif

  // Reset shows y=0 with empty=1, so it follows the blanking rule too.
  localparam logic [6:0] SEG_DARK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO = 7'b0000001;
  localparam logic [6:0] SEG_RST  = BLANK ? SEG_DARK : SEG_ZERO;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  xr_q, xr_d;
  logic [IDX_W-1:0]  y_q, y_d;
  logic              empty_q, empty_d;
  logic              ov_q, ov_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIG_W-1:0]  digit_q, digit_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic [NIB_W-1:0]  y_ext;
  logic [NIB_W-1:0]  y_shift;
  logic [3:0]        nib;

  // Lowest-to-highest scan: the last set bit seen is the highest one.
  function automatic logic [IDX_W-1:0] hi_index(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_font(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Handshake / encode FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    xr_d     = xr_q;
    y_d      = y_q;
    empty_d  = empty_q;
    ov_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          xr_d    = x;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        y_d     = hi_index(xr_q);
        empty_d = (xr_q == '0);
        ov_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Display scan. seg/an are computed from the *next* digit and *next* y so
  // the registered pair always changes together on one edge.
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
    end
    y_ext   = NIB_W'(y_d);
    y_shift = y_ext >> {digit_d, 2'b00};
    nib     = y_shift[3:0];
    seg_d   = (BLANK && empty_d) ? SEG_DARK : seg_font(nib);
    an_d    = ~(DIGITS'(1) << digit_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr_q    <= '0;
      y_q     <= '0;
      empty_q <= 1'b1;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
      digit_q <= '0;
      seg_q   <= SEG_RST;
      an_q    <= ~DIGITS'(1);
    end else begin
      xr_q    <= xr_d;
      y_q     <= y_d;
      empty_q <= empty_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign out_valid = ov_q;
  assign y         = y_q;
  assign empty     = empty_q;
  assign seg       = seg_q;
  assign an        = an_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_enc_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_enc_seg_scan
// Purpose  : Self-checking bench for prio_enc_seg_scan (WIDTH=16, DIGITS=2,
//            SCAN_DIV=4): table of encode vectors plus hand-written sequences
//            for back-to-back input, scan timing and mid-encode reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_prio_enc_seg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic        out_valid;
  logic [3:0]  y;
  logic        empty;
  logic [6:0]  seg;
  logic [1:0]  an;

  int n_pass  = 0;
  int n_total = 0;

`ifdef BLANK_EMPTY_EN
  localparam logic BLANK = 1'b1;
`else
  localparam logic BLANK = 1'b0;
`endif

  logic [6:0] font [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000 };

  prio_enc_seg_scan #(.WIDTH(16), .DIGITS(2), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .y(y), .empty(empty), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Reference scan position: 4 cycles per digit, 2 digits.
  logic [1:0] m_cnt;
  logic       m_dig;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 2'd0;
      m_dig <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 2'd1;
      if (m_cnt == 2'd3) m_dig <= ~m_dig;
    end
  end

  function automatic logic [6:0] exp_seg(input logic [3:0] yv, input logic emp,
                                         input logic dig);
    logic [3:0] n;
    n = dig ? 4'h0 : yv;   // y is 4 bits, so digit 1 is always "0"
    if (BLANK && emp) return 7'b1111111;
    return font[n];
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until an equals e, sampling at negedges.
  task automatic wait_an(input logic [1:0] e, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an === e) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_total++;
      $display("FAIL %s: timeout waiting for an=%b (got %b)", name, e, an);
    end
  endtask

  typedef struct {
    logic [15:0] x;
    logic [3:0]  y;
    logic        empty;
  } vec_t;

  vec_t tv [7];

  logic [1:0] run_an;
  int         run_len;

  initial begin
    tv[0] = '{16'h8001, 4'd15, 1'b0};
    tv[1] = '{16'h0000, 4'd0,  1'b1};
    tv[2] = '{16'h0004, 4'd2,  1'b0};
    tv[3] = '{16'h0001, 4'd0,  1'b0};
    tv[4] = '{16'h0100, 4'd8,  1'b0};
    tv[5] = '{16'h7FFE, 4'd14, 1'b0};
    tv[6] = '{16'h0A50, 4'd11, 1'b0};

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_empty", empty, 1);
    chk("rst_an", an, 2'b10);
    chk("rst_seg", seg, BLANK ? 7'b1111111 : 7'b0000001);
    step();

    // ---------------- table-driven encodes ----------------
    for (int i = 0; i < 7; i++) begin
      x = tv[i].x;
      in_valid = 1'b1;
      @(negedge clk);
      chk("v_ready_idle", in_ready, 1);
      step();
      // BUSY: a valid vector here must be ignored
      x = 16'hFFFF;
      in_valid = 1'b1;
      @(negedge clk);
      chk("v_ready_busy", in_ready, 0);
      chk("v_ov_busy", out_valid, 0);
      step();
      in_valid = 1'b0;
      x = 16'h0000;
      @(negedge clk);
      chk("v_ov_pulse", out_valid, 1);
      chk("v_y", y, tv[i].y);
      chk("v_empty", empty, tv[i].empty);
      chk("v_an", an, m_dig ? 2'b01 : 2'b10);
      chk("v_seg", seg, exp_seg(tv[i].y, tv[i].empty, m_dig));
      step();
      @(negedge clk);
      chk("v_ov_low", out_valid, 0);
      chk("v_y_hold", y, tv[i].y);
      step();
    end

    // ---------------- 8001 -> digit 0 shows F, digit 1 shows 0 ----------------
    x = 16'h8001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("f_ov", out_valid, 1);
    chk("f_y", y, 15);
    wait_an(2'b10, "f_wait_d0");
    chk("f_seg_d0", seg, 7'b0111000);
    wait_an(2'b01, "f_wait_d1");
    chk("f_seg_d1", seg, 7'b0000001);
    step();

    // ---------------- in_valid held high, x changes every cycle ----------------
    begin
      logic [15:0] bx [6];
      logic [3:0]  by [6];
      bx = '{16'h0010, 16'hFFFF, 16'h0300, 16'h1234, 16'h0002, 16'h8000};
      by = '{4'd4, 4'd15, 4'd9, 4'd12, 4'd1, 4'd15};
      for (int i = 0; i < 6; i++) begin
        x = bx[i];
        in_valid = 1'b1;
        @(negedge clk);
        chk("b2b_ready", in_ready, (i % 2 == 0) ? 1 : 0);
        chk("b2b_ov", out_valid, (i >= 2 && i % 2 == 0) ? 1 : 0);
        if (i >= 2 && i % 2 == 0) chk("b2b_y", y, by[i-2]);
        step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_ov_last", out_valid, 1);
      chk("b2b_y_last", y, by[4]);
      step();
    end

    // ---------------- scan timing: 10, 01, 10 with 4 cycles per digit -------
    // y is now 1: digit 0 shows "1", digit 1 shows "0".
    wait_an(2'b01, "scan_sync");
    wait_an(2'b10, "scan_start");
    for (int r = 0; r < 2; r++) begin
      run_an = an;
      chk("scan_seg", seg, (run_an == 2'b10) ? 7'b1001111 : 7'b0000001);
      run_len = 1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (an !== run_an) break;
        run_len++;
      end
      chk("scan_len", run_len, 4);
      chk("scan_next", an, (run_an == 2'b10) ? 2'b01 : 2'b10);
    end
    step();

    // ---------------- reset during BUSY ----------------
    x = 16'h4000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rb_in_ready", in_ready, 1);
    chk("rb_out_valid", out_valid, 0);
    chk("rb_y", y, 0);
    chk("rb_empty", empty, 1);
    chk("rb_an", an, 2'b10);
    chk("rb_seg", seg, BLANK ? 7'b1111111 : 7'b0000001);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rb_no_pulse", out_valid, 0);
      chk("rb_y_hold", y, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
